// File: rtl/and_tree_zero_locator.sv
// rtl/and_tree_zero_locator.sv - locates the lowest-index zero of a vector by walking the AND-tree split
// Optional macro AND_TREE_ZERO_LOCATOR_DEPTH_EN adds the depth output (SEARCH cycles per result).
module and_tree_zero_locator #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:N-1]     x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             all_ones,
`ifdef AND_TREE_ZERO_LOCATOR_DEPTH_EN
    output logic [IDX_W:0]   depth,
`endif
    output logic [IDX_W-1:0] idx
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CW = CW'(N);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [0:N-1]     xr_q, xr_d;
    logic [CW-1:0]    lo_q, lo_d;
    logic [CW-1:0]    len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             all_ones_q, all_ones_d;
`ifdef AND_TREE_ZERO_LOCATOR_DEPTH_EN
    logic [IDX_W:0]   depth_q, depth_d;
`endif

    logic [CW-1:0] n1, new_lo, new_len;
    logic          left_zero;

    // Left half of the current window is xr[lo .. lo+n1-1]; it holds a zero iff its AND is 0.
    always_comb begin
        n1        = len_q >> 1;
        left_zero = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(lo_q) && i < int'(lo_q) + int'(n1) && !xr_q[i]) begin
                left_zero = 1'b1;
            end
        end
        if (left_zero) begin
            new_lo  = lo_q;
            new_len = n1;
        end else begin
            new_lo  = lo_q + n1;
            new_len = len_q - n1;
        end
    end

    always_comb begin
        state_d    = state_q;
        xr_d       = xr_q;
        lo_d       = lo_q;
        len_d      = len_q;
        idx_d      = idx_q;
        all_ones_d = all_ones_q;
`ifdef AND_TREE_ZERO_LOCATOR_DEPTH_EN
        depth_d    = depth_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    xr_d       = x;
                    lo_d       = '0;
                    len_d      = N_CW;
                    idx_d      = '0;
                    all_ones_d = 1'b0;
`ifdef AND_TREE_ZERO_LOCATOR_DEPTH_EN
                    depth_d    = '0;
`endif
                    if (&x) begin
                        all_ones_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (N == 1) begin
                        state_d    = S_DONE;
                    end else begin
                        state_d    = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                lo_d  = new_lo;
                len_d = new_len;
`ifdef AND_TREE_ZERO_LOCATOR_DEPTH_EN
                depth_d = depth_q + 1'b1;
`endif
                if (new_len == CW'(1)) begin
                    idx_d      = new_lo[IDX_W-1:0];
                    all_ones_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            xr_q       <= '0;
            lo_q       <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            all_ones_q <= 1'b0;
`ifdef AND_TREE_ZERO_LOCATOR_DEPTH_EN
            depth_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            xr_q       <= xr_d;
            lo_q       <= lo_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            all_ones_q <= all_ones_d;
`ifdef AND_TREE_ZERO_LOCATOR_DEPTH_EN
            depth_q    <= depth_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign idx       = idx_q;
    assign all_ones  = all_ones_q;
`ifdef AND_TREE_ZERO_LOCATOR_DEPTH_EN
    assign depth     = depth_q;
`endif

endmodule
